// File: rtl/servo_pwm_decoder.sv
// Servo PWM receive decoder: measures pulse high time, classifies it into a 2-bit position code,
// flags malformed pulses and loss of signal. Define PWM_DEC_GLITCH_FILTER_EN for the input filter.
module servo_pwm_decoder #(
    parameter int unsigned MIN_PULSE     = 25000,
    parameter int unsigned MAX_PULSE     = 125000,
    parameter int unsigned TH_1          = 62500,
    parameter int unsigned TH_2          = 87500,
    parameter int unsigned FRAME_TIMEOUT = 1500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [17:0] width_out,
    output logic [1:0]  code,
    output logic        valid,
    output logic        err,
    output logic        signal_lost
);

    typedef enum logic [1:0] {StArm, StWaitRise, StHigh} state_e;

    localparam logic [17:0] MinW     = 18'(MIN_PULSE);
    localparam logic [17:0] MaxW     = 18'(MAX_PULSE);
    localparam logic [17:0] Th1W     = 18'(TH_1);
    localparam logic [17:0] Th2W     = 18'(TH_2);
    localparam logic [21:0] TimeoutW = 22'(FRAME_TIMEOUT);

    logic        sync1_q, sync2_q, s, s_prev_q, rise;
    state_e      state_q, state_d;
    logic [17:0] cnt_q, cnt_d, width_q, width_d;
    logic [1:0]  code_q, code_d, arm_cnt_q, arm_cnt_d;
    logic [21:0] timer_q, timer_d;
    logic        valid_q, valid_d, err_q, err_d, lost_q, lost_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            s_prev_q <= s;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic       s_q, s_d;
    logic [1:0] filt_cnt_q, filt_cnt_d;

    // Commit a new level after three differing sync2 samples plus a matching fourth in sync1.
    always_comb begin
        s_d        = s_q;
        filt_cnt_d = 2'd0;
        if (sync2_q != s_q) begin
            if (filt_cnt_q == 2'd2 && sync1_q == sync2_q) begin
                s_d = sync2_q;
            end else if (filt_cnt_q != 2'd2) begin
                filt_cnt_d = filt_cnt_q + 2'd1;
            end else begin
                filt_cnt_d = filt_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= 1'b0;
            filt_cnt_q <= 2'd0;
        end else begin
            s_q        <= s_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign s = s_q;
`else
    assign s = sync2_q;
`endif

    assign rise = s & ~s_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arm_cnt_d = 2'd0;
        width_d   = width_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            // Require a sustained low through the whole chain so a pulse live at reset is skipped.
            StArm: begin
                if (!sync1_q && !s) begin
                    if (arm_cnt_q == 2'd2) begin
                        state_d = StWaitRise;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 2'd1;
                    end
                end
            end
            StWaitRise: begin
                if (rise) begin
                    state_d = StHigh;
                    cnt_d   = 18'd1;
                end
            end
            StHigh: begin
                if (!s) begin
                    state_d = StWaitRise;
                    if (cnt_q < MinW) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        width_d = cnt_q;
                        if (cnt_q < Th1W) begin
                            code_d = 2'd0;
                        end else if (cnt_q < Th2W) begin
                            code_d = 2'd1;
                        end else begin
                            code_d = 2'd2;
                        end
                    end
                end else if (cnt_q == MaxW) begin
                    cnt_d   = MaxW + 18'd1;
                    err_d   = 1'b1;
                    state_d = StArm;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
            default: state_d = StArm;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        lost_d  = lost_q;
        if (rise) begin
            timer_d = 22'd0;
        end else if (timer_q != TimeoutW) begin
            timer_d = timer_q + 22'd1;
        end
        if (valid_d) begin
            lost_d = 1'b0;
        end else if (timer_d == TimeoutW) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StArm;
            cnt_q     <= 18'd0;
            arm_cnt_q <= 2'd0;
            width_q   <= 18'd0;
            code_q    <= 2'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timer_q   <= 22'd0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arm_cnt_q <= arm_cnt_d;
            width_q   <= width_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            lost_q    <= lost_d;
        end
    end

    assign width_out   = width_q;
    assign code        = code_q;
    assign valid       = valid_q;
    assign err         = err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with scaled-down timing parameters and a strobe scoreboard.
module tb_servo_pwm_decoder;

    localparam int MIN_P = 50;
    localparam int MAX_P = 250;
    localparam int TH1   = 125;
    localparam int TH2   = 175;
    localparam int TOUT  = 3000;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [17:0] width_out;
    logic [1:0]  code;
    logic        valid, err, signal_lost;

    servo_pwm_decoder #(
        .MIN_PULSE    (MIN_P),
        .MAX_PULSE    (MAX_P),
        .TH_1         (TH1),
        .TH_2         (TH2),
        .FRAME_TIMEOUT(TOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .width_out  (width_out),
        .code       (code),
        .valid      (valid),
        .err        (err),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [17:0] width;
        logic [1:0]  code;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [17:0] last_w = 18'd0;
    logic [1:0]  last_c = 2'd0;
    int          last_rise = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_err(input int at);
        exp_t e;
        e.is_err = 1'b1;
        e.width  = last_w;
        e.code   = last_c;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic push_valid(input int w, input int at);
        exp_t e;
        e.is_err = 1'b0;
        e.width  = 18'(w);
        e.code   = (w < TH1) ? 2'd0 : (w < TH2) ? 2'd1 : 2'd2;
        e.at     = at;
        last_w   = e.width;
        last_c   = e.code;
        sb.push_back(e);
    endtask

    // Pulse of w clocks synchronous to the bench clock, followed by gap low clocks.
    task automatic pulse(input int w, input int gap);
        int k0;
        pwm_in    = 1'b1;
        k0        = cyc;
        last_rise = k0;
        if (w > MAX_P) push_err(k0 + MAX_P + LAT);
        step(w);
        pwm_in = 1'b0;
        if (w < MIN_P) push_err(cyc + LAT);
        else if (w <= MAX_P) push_valid(w, cyc + LAT);
        step(gap);
    endtask

    // Scoreboard consumer plus output-stability and exclusivity checks.
    logic [17:0] pw = 18'd0;
    logic [1:0]  pc = 2'd0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            pw = 18'd0;
            pc = 2'd0;
        end else begin
            if (!valid) begin
                chk("width_stable", 32'(width_out), 32'(pw));
                chk("code_stable", 32'(code), 32'(pc));
            end
            if (valid || err) begin
                chk("valid_err_excl", 32'(valid & err), 32'(0));
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'({valid, err}), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind_err", 32'(err), 32'(e.is_err));
                    chk("strobe_cycle", 32'(cyc), 32'(e.at));
                    chk("width_out", 32'(width_out), 32'(e.width));
                    chk("code", 32'(code), 32'(e.code));
                    if (!e.is_err) chk("lost_clr_on_valid", 32'(signal_lost), 32'(0));
                end
            end
            pw = width_out;
            pc = code;
        end
    end

    initial begin
        int k0;
        // Reset with the input already high: the pulse in progress must not be measured.
        pwm_in = 1'b1;
        step(5);
        chk("rst_width", 32'(width_out), 32'(0));
        chk("rst_code", 32'(code), 32'(0));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_lost", 32'(signal_lost), 32'(0));
        rst_n = 1'b1;
        step(100);
        pwm_in = 1'b0;
        step(300);
        pulse(100, 300);

        // Classification.
        pulse(100, 300);
        pulse(150, 300);
        pulse(200, 300);

        // Boundaries.
        pulse(MIN_P - 1, 300);
        pulse(MIN_P, 300);
        pulse(TH1 - 1, 300);
        pulse(TH1, 300);
        pulse(TH2, 300);
        pulse(MAX_P, 300);

        // Overlong pulse, then recovery.
        pulse(400, 300);
        pulse(150, 300);

        // Short glitch during a low period.
        pwm_in = 1'b1;
        step(2);
        pwm_in = 1'b0;
`ifndef PWM_DEC_GLITCH_FILTER_EN
        push_err(cyc + LAT);
`endif
        step(300);
        pulse(100, 300);

        // Reset asserted mid-pulse.
        chk("sb_empty_pre_reset", 32'(sb.size()), 32'(0));
        pwm_in = 1'b1;
        step(30);
        rst_n = 1'b0;
        #1;
        chk("async_rst_width", 32'(width_out), 32'(0));
        chk("async_rst_code", 32'(code), 32'(0));
        last_w = 18'd0;
        last_c = 2'd0;
        step(3);
        rst_n = 1'b1;
        step(100);
        pwm_in = 1'b0;
        step(300);
        pulse(150, 300);

        // Loss of signal: timeout boundary, bare edge does not clear, valid does.
        pulse(100, 0);
        k0 = last_rise;
        step(k0 + LAT + TOUT - 1 - cyc);
        chk("lost_before_timeout", 32'(signal_lost), 32'(0));
        step(1);
        chk("lost_at_timeout", 32'(signal_lost), 32'(1));
        pwm_in = 1'b1;
        step(20);
        chk("lost_held_after_rise", 32'(signal_lost), 32'(1));
        step(180);
        pwm_in = 1'b0;
        push_valid(200, cyc + LAT);
        step(20);
        chk("lost_cleared", 32'(signal_lost), 32'(0));

        chk("sb_empty_end", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart to the servo PWM generator: measures the high time of an incoming servo-style PWM signal (the command line driven by the mbed), classifies it into a 2-bit position command (red/green/blue), and flags malformed or missing frames. Sits between the mbed command pin and the servo position logic, replacing the three separate colour lines with one pulse-width-coded wire. Clock assumed 50 MHz (20 ns); all parameters are in clock ticks.

## Interface
- `MIN_PULSE`, 25000: shortest legal high time (0.5 ms).
- `MAX_PULSE`, 125000: longest legal high time (2.5 ms).
- `TH_1`, 62500: width < TH_1 → code 0 (red).
- `TH_2`, 87500: TH_1 ≤ width < TH_2 → code 1 (green); width ≥ TH_2 → code 2 (blue).
- `FRAME_TIMEOUT`, 1500000: ticks without a rising edge before signal is declared lost (30 ms).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `pwm_in`  in  1  asynchronous PWM command from mbed.
- `width_out`  out  18  high time of last accepted pulse, in ticks.
- `code`  out  2  position of last accepted pulse: 0 red, 1 green, 2 blue; 3 never driven.
- `valid`  out  1  one-cycle strobe: width_out/code just updated.
- `err`  out  1  one-cycle strobe: pulse rejected (too short or too long).
- `signal_lost`  out  1  level: no rising edge for FRAME_TIMEOUT ticks.

## Operation
- Input path: 2-FF synchronizer on pwm_in → `s`; edges detected on `s` versus its previous value.
- States: ARM, WAIT_RISE, HIGH.
  - ARM: entered on reset and after an overlong pulse; wait for `s`=0, then WAIT_RISE. A pulse already in progress at reset is never measured.
  - WAIT_RISE: rising edge → HIGH, high counter = 1.
  - HIGH: counter increments each cycle `s`=1. Falling edge → evaluate, go to WAIT_RISE. Counter reaching MAX_PULSE+1 while high → err strobe, go to ARM (no second err for same pulse).
- Evaluate: count < MIN_PULSE → err strobe, outputs unchanged. Otherwise width_out = count, code per TH_1/TH_2, valid strobe.
- Boundaries inclusive: count = MIN_PULSE and count = MAX_PULSE accepted; count = TH_1 → 1; count = TH_2 → 2.
- Frame timer: 22-bit, cleared on every rising edge, otherwise increments, saturates at FRAME_TIMEOUT. Reaching FRAME_TIMEOUT sets signal_lost. signal_lost clears only on a valid strobe, not on a bare rising edge.
- Rising edge and timeout in same cycle: edge wins; timer cleared, signal_lost not set.
- valid and err never assert in the same cycle.

## Timing
- Reset values: width_out 0, code 0, valid 0, err 0, signal_lost 0, state ARM, counters 0.
- Reset mid-pulse: all outputs return to reset values immediately; next measurement waits for a low on `s`.
- width_out equals number of clocks `s` was high (exact for a synchronous-aligned input; ±1 tick for asynchronous input).
- Latency, pwm_in fall → valid/err: 3 clocks (2 sync + 1 evaluate register), without filter.
- Overlong err: asserts the cycle the counter reaches MAX_PULSE+1, not at the falling edge.
- width_out/code change only in the valid cycle; stable otherwise.

## Configuration
- `PWM_DEC_GLITCH_FILTER_EN` defined: after the synchronizer, `s` changes only when the synchronized input has held the new level for 4 consecutive clocks; glitches of ≤3 clocks are ignored; rise and fall both delayed 3 extra clocks, so width_out is unchanged for clean pulses and latency becomes 6 clocks.
- Undefined: `s` is the raw 2-FF synchronizer output; a 1-clock glitch is a full edge (a short high glitch yields err).

## Test plan
- Reset mid-pulse: pwm_in high, release rst_n, hold 50000 ticks, drop → no valid, no err; next 50000-tick pulse → valid, width_out 50000, code 0.
- Classification: pulses of 50000, 75000, 100000 ticks at 20 ms period → code 0, 1, 2; valid 3 clocks after each fall.
- Boundaries: 24999 → err; 25000 → valid code 0; 62499 → 0; 62500 → 1; 87500 → 2; 125000 → valid code 2.
- Overlong: hold high 200000 ticks → single err at tick 125001 after rise, no valid; following 75000-tick pulse → valid, code 1.
- Loss of signal: valid pulse then input low for 1500000 ticks → signal_lost=1; next 100000-tick pulse → valid, code 2, signal_lost=0 same cycle.
- Glitch: 2-clock high glitch during a low period → with filter no err/valid; without filter → err.
